// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux_pkg;

  localparam int N_OUT = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output slot: holds a single item until the downstream side takes it.
// A load in the same cycle as a drain replaces the item without a bubble.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] ld_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  slot_state_t  state_reg;
  slot_state_t  state_next;
  logic [W-1:0] data_reg;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: fill on load, empty on drain unless reloaded in the same cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:   if (load) state_next = FULL;
      FULL:    if (ready && !load) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Item storage only changes on a load, so data is stable while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= ld_data;
    end
  end

  assign valid = (state_reg == FULL);
  assign data  = data_reg;

endmodule

// File: rtl/demux_1_4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with one buffered slot per channel.
// Optional feature: define DEMUX_1_4_STREAM_COUNT_EN to add per-channel
// drained-item counters on output cnt.
module demux_1_4_stream
  import demux_pkg::*;
#(
  parameter int W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  sel_t               sel,
  output logic [N_OUT-1:0]   out_valid,
  input  logic [N_OUT-1:0]   out_ready,
  output logic [N_OUT*W-1:0] out_data
`ifdef DEMUX_1_4_STREAM_COUNT_EN
  ,
  output logic [N_OUT*CNT_W-1:0] cnt
`endif
);

  logic             accept;
  logic [N_OUT-1:0] load;

  // The selected slot can take an item if it is empty or draining this cycle;
  // deliberately independent of in_valid to avoid a valid->ready loop.
  assign in_ready = !out_valid[sel] || out_ready[sel];
  assign accept   = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_slot
      assign load[gi] = accept && (sel == sel_t'(gi));

      demux_out_slot #(.W(W)) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load[gi]),
        .ld_data (in_data),
        .ready   (out_ready[gi]),
        .valid   (out_valid[gi]),
        .data    (out_data[gi*W +: W])
      );
    end
  endgenerate

`ifdef DEMUX_1_4_STREAM_COUNT_EN
  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      // Count completed drains; wraps naturally at 2**CNT_W.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (out_valid[gi] && out_ready[gi]) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign cnt[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed bench for demux_1_4_stream with a per-channel reference model.
module tb_demux_1_4_stream;
  import demux_pkg::*;

  localparam int W = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [W-1:0]       in_data = '0;
  logic [1:0]         sel = 2'd0;
  logic [N_OUT-1:0]   out_valid;
  logic [N_OUT-1:0]   out_ready = '0;
  logic [N_OUT*W-1:0] out_data;
`ifdef DEMUX_1_4_STREAM_COUNT_EN
  logic [N_OUT*CNT_W-1:0] cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  demux_1_4_stream #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_1_4_STREAM_COUNT_EN
    ,
    .cnt       (cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: each channel is a one-item box that is either occupied or not.
  bit         m_full [N_OUT];
  logic [W-1:0] m_item [N_OUT];
  int         m_cnt  [N_OUT];

  always @(posedge clk) begin
    bit acc;
    acc = in_valid && (!m_full[sel] || out_ready[sel]);
    for (int i = 0; i < N_OUT; i++) begin
      if (!rst_n) begin
        m_full[i] <= 1'b0;
        m_item[i] <= '0;
        m_cnt[i]  <= 0;
      end else begin
        if (m_full[i] && out_ready[i]) begin
          m_full[i] <= 1'b0;
          m_cnt[i]  <= (m_cnt[i] + 1) % 256;
        end
        if (acc && sel == i) begin
          m_full[i] <= 1'b1;
          m_item[i] <= in_data;
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      bit exp_rdy;
      exp_rdy = !m_full[sel] || out_ready[sel];
      n_cmp++;
      if (in_ready !== exp_rdy) begin
        n_bad++;
        $display("FAIL model_in_ready t=%0t got=%b want=%b", $time, in_ready, exp_rdy);
      end
      for (int i = 0; i < N_OUT; i++) begin
        n_cmp++;
        if (out_valid[i] !== m_full[i]) begin
          n_bad++;
          $display("FAIL model_valid[%0d] t=%0t got=%b want=%b", i, $time, out_valid[i], m_full[i]);
        end
        if (m_full[i]) begin
          n_cmp++;
          if (out_data[i*W +: W] !== m_item[i]) begin
            n_bad++;
            $display("FAIL model_data[%0d] t=%0t got=%h want=%h", i, $time, out_data[i*W +: W], m_item[i]);
          end
        end
`ifdef DEMUX_1_4_STREAM_COUNT_EN
        n_cmp++;
        if (cnt[i*CNT_W +: CNT_W] !== m_cnt[i][CNT_W-1:0]) begin
          n_bad++;
          $display("FAIL model_cnt[%0d] t=%0t got=%0d want=%0d", i, $time, cnt[i*CNT_W +: CNT_W], m_cnt[i]);
        end
`endif
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  // Advance one clock and leave inputs/outputs settled just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    cmp_en = 1'b1;

    // Reset state: nothing valid, data cleared, ready for every destination.
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    for (int s = 0; s < N_OUT; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("rst_in_ready_sel%0d", s), 32'(in_ready), 32'h1);
    end

    // Single item 0xA to channel 2.
    in_valid = 1'b1; in_data = 4'hA; sel = 2'd2;
    step();
    in_valid = 1'b0;
    check("single_valid", 32'(out_valid), 32'h4);
    check("single_data2", 32'(out_data[2*W +: W]), 32'hA);

    // Backpressure on channel 1, then release with load-during-drain.
    do_reset();
    in_valid = 1'b1; in_data = 4'h3; sel = 2'd1;
    step();
    in_data = 4'h9;
    #1;
    check("bp_in_ready_low", 32'(in_ready), 32'h0);
    step();
    check("bp_held_valid1", 32'(out_valid[1]), 32'h1);
    check("bp_held_data1", 32'(out_data[1*W +: W]), 32'h3);
    out_ready = 4'b0010;
    #1;
    check("bp_in_ready_high", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0; out_ready = '0;
    check("bp_nobubble_valid1", 32'(out_valid[1]), 32'h1);
    check("bp_new_data1", 32'(out_data[1*W +: W]), 32'h9);

    // Back-to-back fill of all channels with all outputs stalled.
    do_reset();
    for (int k = 0; k < N_OUT; k++) begin
      in_valid = 1'b1; sel = 2'(k); in_data = 4'(k + 1);
      step();
    end
    in_valid = 1'b0;
    check("fill_valid", 32'(out_valid), 32'hF);
    check("fill_data", 32'(out_data), 32'h4321);

    // Streaming into channel 3 with its output always ready.
    out_ready = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; sel = 2'd3; in_data = 4'(5 + k);
      step();
      check($sformatf("stream_valid3_%0d", k), 32'(out_valid[3]), 32'h1);
      check($sformatf("stream_data3_%0d", k), 32'(out_data[3*W +: W]), 32'(5 + k));
    end
    in_valid = 1'b0;
    step();
    out_ready = '0;
    check("stream_drained3", 32'(out_valid[3]), 32'h0);

    // Reset while channels 0 and 2 hold items discards them.
    do_reset();
    in_valid = 1'b1; sel = 2'd0; in_data = 4'h7;
    step();
    sel = 2'd2; in_data = 4'hC;
    step();
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'h5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    sel = 2'd2;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_in_ready", 32'(in_ready), 32'h1);

`ifdef DEMUX_1_4_STREAM_COUNT_EN
    // 257 drains on channel 1 wrap its counter to 1.
    do_reset();
    out_ready = 4'b0010;
    for (int k = 0; k < 257; k++) begin
      in_valid = 1'b1; sel = 2'd1; in_data = 4'(k);
      step();
    end
    in_valid = 1'b0;
    step();
    out_ready = '0;
    check("cnt1_wrap", 32'(cnt[1*CNT_W +: CNT_W]), 32'h1);
    check("cnt_others", 32'({cnt[3*CNT_W +: CNT_W], cnt[2*CNT_W +: CNT_W], cnt[0 +: CNT_W]}), 32'h0);
`endif

    step();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux_1_4_stream.md
DEMUX_1_4_STREAM -- requirements
Module: demux_1_4_stream

Interface
REQ-001 SHALL have parameter: W, default 4, data width per channel.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  upstream item present.
REQ-005 SHALL have port: in_ready  output  1  block accepts the item this cycle.
REQ-006 SHALL have port: in_data  input  W  upstream item.
REQ-007 SHALL have port: sel  input  2  destination channel index 0..3; sampled only on an accepted transfer.
REQ-008 SHALL have ports: out_valid  output  4  per-channel item present (bit i for channel i).
REQ-009 SHALL have ports: out_ready  input  4  per-channel downstream accept.
REQ-010 SHALL have ports: out_data  output  4xW  per-channel item, packed, channel i at bits [i*W +: W].

Function
REQ-011 SHALL hold one slot per channel, each a 2-state FSM: EMPTY and FULL.
REQ-012 SHALL drive in_ready = (slot[sel] EMPTY) or out_ready[sel], combinationally; it SHALL NOT depend on in_valid.
REQ-013 SHALL accept a transfer when in_valid and in_ready are both 1 in the same cycle.
REQ-014 SHALL load in_data into slot[sel] on acceptance, giving out_valid[sel]=1 on the next cycle (latency 1 cycle).
REQ-015 SHALL drain slot i when out_valid[i] and out_ready[i] are both 1: FULL->EMPTY unless reloaded in that cycle.
REQ-016 SHALL, on simultaneous drain and load of the same slot, store the new item and keep out_valid[i]=1 with no bubble.
REQ-017 SHALL allow a load into one channel and drains on any others in the same cycle, independently.
REQ-018 SHALL hold out_data[i] stable while out_valid[i]=1 and out_ready[i]=0.
REQ-019 SHALL drive out_data of an EMPTY slot to its last stored value; the value is don't-care for checking.
REQ-020 SHALL NOT alter non-selected slots on a transfer, and SHALL NOT block a channel because of stalls on other channels.

Reset
REQ-021 SHALL, while rst_n=0 at a rising edge, set all slots EMPTY, out_valid=4'b0000, and out_data=0.
REQ-022 SHALL discard any in-flight item when reset is asserted mid-operation; no output SHALL be valid on the first cycle after reset.
REQ-023 SHALL keep in_ready=1 after reset for any sel, because all slots are EMPTY.

Configuration
REQ-024 SHALL, with DEMUX_1_4_STREAM_COUNT_EN defined, add output cnt (4x8 bits): per-channel count of drained items.
REQ-025 SHALL increment cnt[i] by 1 on each drain of channel i, wrap 255->0, and clear to 0 on reset.
REQ-026 SHALL, without DEMUX_1_4_STREAM_COUNT_EN, omit the cnt port and all counter logic entirely.

Structure
REQ-027 SHALL place in package demux_pkg: N_OUT=4, SEL_W=2, CNT_W=8, typedef sel_t (logic [1:0]), and typedef enum slot_state_t {EMPTY, FULL}.
REQ-028 SHALL implement each channel slot as sub-module demux_out_slot (load, data, ready in; valid, data out; parameter W), instantiated 4 times.

Verification
REQ-029 SHALL pass: after reset, in_data=4'hA, sel=2, in_valid=1 for one cycle -> next cycle out_valid=4'b0100, out_data[2]=4'hA.
REQ-030 SHALL pass: slot 1 FULL with out_ready[1]=0, new item for sel=1 -> in_ready=0, item held; raise out_ready[1] -> in_ready=1 in the same cycle and the item is loaded with no bubble.
REQ-031 SHALL pass: back-to-back items 1,2,3,4 to sel=0,1,2,3 with all out_ready=0 -> out_valid=4'b1111 and out_data=4,3,2,1 (channel 3..0).
REQ-032 SHALL pass: streaming 5,6,7 to sel=3 with out_ready[3]=1 -> one item per cycle, in order, with out_valid[3] continuously 1.
REQ-033 SHALL pass: rst_n=0 while channels 0 and 2 are FULL -> next cycle out_valid=0000 and in_ready=1.
REQ-034 SHALL pass (COUNT_EN defined): 257 drains on channel 1 -> cnt[1]=1, and the other counts stay 0.
